// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: kind codes, opcodes, ALU code table and NOP word for the RV32IM instruction encoder
package rv_enc_pkg;
  typedef enum logic [3:0] {K_R, K_ICAL, K_LOAD, K_JALR, K_S, K_B, K_LUI, K_AUIPC, K_JAL} kind_e;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
    ALU_REM, ALU_REMU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL = 5'd14, ALU_SRL, ALU_SRA, ALU_SLTU, ALU_SLT
  } alu_e;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ICAL  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;
  localparam logic [6:0] F7_M     = 7'h01;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  typedef struct packed {
    logic       ok;
    logic [6:0] f7;
    logic [2:0] f3;
  } alu_enc_t;
  function automatic alu_enc_t alu_enc(input logic [4:0] c);
    case (c)
      ALU_ADD:    return '{1'b1, F7_BASE, 3'd0};
      ALU_SUB:    return '{1'b1, F7_ALT,  3'd0};
      ALU_MUL:    return '{1'b1, F7_M,    3'd0};
      ALU_MULH:   return '{1'b1, F7_M,    3'd1};
      ALU_MULHSU: return '{1'b1, F7_M,    3'd2};
      ALU_MULHU:  return '{1'b1, F7_M,    3'd3};
      ALU_DIV:    return '{1'b1, F7_M,    3'd4};
      ALU_DIVU:   return '{1'b1, F7_M,    3'd5};
      ALU_REM:    return '{1'b1, F7_M,    3'd6};
      ALU_REMU:   return '{1'b1, F7_M,    3'd7};
      ALU_AND:    return '{1'b1, F7_BASE, 3'd7};
      ALU_OR:     return '{1'b1, F7_BASE, 3'd6};
      ALU_XOR:    return '{1'b1, F7_BASE, 3'd4};
      ALU_SLL:    return '{1'b1, F7_BASE, 3'd1};
      ALU_SRL:    return '{1'b1, F7_BASE, 3'd5};
      ALU_SRA:    return '{1'b1, F7_ALT,  3'd5};
      ALU_SLTU:   return '{1'b1, F7_BASE, 3'd3};
      ALU_SLT:    return '{1'b1, F7_BASE, 3'd2};
      default:    return '{1'b0, F7_BASE, 3'd0};
    endcase
  endfunction
endpackage

// File: rtl/enc_fifo2.sv
// enc_fifo2: 2-entry FIFO holding {err,inst}; rdata reads as zero while empty
module enc_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  logic         do_push, do_pop;
  assign full    = cnt[1];
  assign empty   = cnt == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes decoded-field requests into RV32IM words with legality check, 2-entry buffer and address/word counters
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_alu_ctl,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [15:0]       word_cnt
);
  alu_enc_t          a;
  logic              ok, s12, s13, s21, shift, full, empty, accept, pop;
  logic [31:0]       word, enc;
  logic [ADDR_W-1:0] ptr;
  assign a     = alu_enc(in_alu_ctl);
  assign s12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign s13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign s21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign shift = in_alu_ctl == ALU_SLL || in_alu_ctl == ALU_SRL || in_alu_ctl == ALU_SRA;
  always_comb begin
    ok   = 1'b0;
    word = NOP;
    case (in_kind)
      K_R: begin
        ok   = a.ok;
        word = {a.f7, in_rs2, in_rs1, a.f3, in_rd, OP_R};
      end
      K_ICAL: begin
        ok   = a.ok && a.f7 != F7_M && in_alu_ctl != ALU_SUB && (shift ? in_imm[31:5] == '0 : s12);
        word = shift ? {a.f7, in_imm[4:0], in_rs1, a.f3, in_rd, OP_ICAL}
                     : {in_imm[11:0], in_rs1, a.f3, in_rd, OP_ICAL};
      end
      K_LOAD: begin
        ok   = s12 && in_funct3 != 3'd3 && in_funct3 < 3'd6;
        word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      end
      K_JALR: begin
        ok   = s12;
        word = {in_imm[11:0], in_rs1, 3'd0, in_rd, OP_JALR};
      end
      K_S: begin
        ok   = s12 && in_funct3 < 3'd3;
        word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      end
      K_B: begin
        ok   = s13 && !in_imm[0] && in_funct3 != 3'd2 && in_funct3 != 3'd3;
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], OP_B};
      end
      K_LUI, K_AUIPC: begin
        ok   = in_imm[11:0] == '0;
        word = {in_imm[31:12], in_rd, in_kind == K_LUI ? OP_LUI : OP_AUIPC};
      end
      K_JAL: begin
        ok   = s21 && !in_imm[0];
        word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      default: ok = 1'b0;
    endcase
  end
  assign enc       = ok ? word : NOP;
  assign in_ready  = ~full;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~empty & ~rst;
  assign pop       = out_valid & out_ready;
  assign out_addr  = ptr;
  enc_fifo2 #(.W(33)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({~ok, enc}),
    .pop   (pop),
    .rdata ({out_err, out_inst}),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= BASE_ADDR;
      word_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      ptr        <= pop ? ptr + ADDR_W'(4) : ptr;
      word_cnt   <= pop ? word_cnt + 16'd1 : word_cnt;
      err_sticky <= err_sticky | (accept & ~ok);
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table-driven and scoreboard self-check of inst_encoder
module tb_inst_encoder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [32:0] E    = {1'b1, 32'h0000_0013};
  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [32:0] exp;
  } vec_t;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_err, err_sticky;
  logic [3:0]  in_kind = 0;
  logic [4:0]  in_alu_ctl = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0]  in_funct3 = 0;
  logic [31:0] in_imm = 0, out_inst, out_addr;
  logic [15:0] word_cnt;
  logic [32:0] q[$];
  logic [31:0] exp_addr = BASE;
  int          pops = 0, n_checks = 0, n_fail = 0;
  logic        rand_rdy = 0;
  vec_t        tv[30];
  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_alu_ctl(in_alu_ctl), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [3:0] k, input logic [4:0] a, input logic [2:0] f,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [32:0] exp);
    return '{k, a, f, rd, rs1, rs2, imm, exp};
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", {1'b0, out_inst}, 33'h1_FFFF_FFFF);
      else begin
        chk("word", {out_err, out_inst}, q.pop_front());
        chk("addr", {1'b0, out_addr}, {1'b0, exp_addr});
      end
      exp_addr = exp_addr + 32'd4;
      pops++;
    end
  end
  always @(posedge clk) if (rand_rdy) #1 out_ready = 1'($urandom_range(0, 1));
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input vec_t v);
    int n = 0;
    in_kind = v.kind; in_alu_ctl = v.alu; in_funct3 = v.f3;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 33'(in_ready), 33'd1);
    else q.push_back(v.exp);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 33'(q.size()), 33'd0);
    idle(1);
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    idle(2);
    rst = 0;
    exp_addr = BASE;
    pops = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tv[0]  = mk(0, 0,  0, 3, 1, 2, 32'h0,        {1'b0, 32'h002081B3});
    tv[1]  = mk(0, 1,  0, 3, 1, 2, 32'h0,        {1'b0, 32'h402081B3});
    tv[2]  = mk(0, 2,  0, 3, 1, 2, 32'h0,        {1'b0, 32'h022081B3});
    tv[3]  = mk(0, 9,  0, 3, 1, 2, 32'h0,        {1'b0, 32'h0220F1B3});
    tv[4]  = mk(0, 13, 0, 3, 1, 2, 32'h0,        E);
    tv[5]  = mk(1, 16, 0, 5, 6, 0, 32'd3,        {1'b0, 32'h40335293});
    tv[6]  = mk(1, 1,  0, 5, 6, 0, 32'd3,        E);
    tv[7]  = mk(1, 0,  0, 1, 0, 0, 32'hFFFFFFFF, {1'b0, 32'hFFF00093});
    tv[8]  = mk(1, 0,  0, 1, 0, 0, 32'd2048,     E);
    tv[9]  = mk(1, 0,  0, 1, 0, 0, 32'hFFFFF800, {1'b0, 32'h80000093});
    tv[10] = mk(1, 14, 0, 1, 0, 0, 32'd32,       E);
    tv[11] = mk(1, 2,  0, 1, 0, 0, 32'd1,        E);
    tv[12] = mk(2, 0,  2, 5, 2, 0, 32'd8,        {1'b0, 32'h00812283});
    tv[13] = mk(2, 0,  3, 5, 2, 0, 32'd8,        E);
    tv[14] = mk(3, 0,  7, 1, 5, 0, 32'd0,        {1'b0, 32'h000280E7});
    tv[15] = mk(4, 0,  2, 0, 2, 5, 32'd12,       {1'b0, 32'h00512623});
    tv[16] = mk(4, 0,  3, 0, 2, 5, 32'd12,       E);
    tv[17] = mk(5, 0,  0, 0, 1, 2, 32'hFFFFFFFC, {1'b0, 32'hFE208EE3});
    tv[18] = mk(5, 0,  0, 0, 1, 2, 32'd3,        E);
    tv[19] = mk(5, 0,  0, 0, 1, 2, 32'd4096,     E);
    tv[20] = mk(5, 0,  2, 0, 1, 2, 32'd4,        E);
    tv[21] = mk(8, 0,  0, 1, 0, 0, 32'd2048,     {1'b0, 32'h001000EF});
    tv[22] = mk(8, 0,  0, 1, 0, 0, 32'h00100000, E);
    tv[23] = mk(6, 0,  0, 5, 0, 0, 32'h12345000, {1'b0, 32'h123452B7});
    tv[24] = mk(6, 0,  0, 5, 0, 0, 32'h12345001, E);
    tv[25] = mk(7, 0,  0, 1, 0, 0, 32'hFFFFF000, {1'b0, 32'hFFFFF097});
    tv[26] = mk(9, 0,  0, 1, 0, 0, 32'h0,        E);
    tv[27] = mk(0, 16, 0, 3, 1, 2, 32'h0,        {1'b0, 32'h4020D1B3});
    tv[28] = mk(1, 15, 0, 5, 6, 0, 32'd3,        {1'b0, 32'h00335293});
    tv[29] = mk(1, 18, 0, 1, 2, 0, 32'd5,        {1'b0, 32'h00512093});
    idle(3);
    rst = 0;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_inst", {out_err, out_inst}, 33'd0);
    chk("rst_err_sticky", 33'(err_sticky), 33'd0);
    chk("rst_word_cnt", 33'(word_cnt), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    out_ready = 1;
    send(tv[0]);
    chk("first_valid", 33'(out_valid), 33'd1);
    drain();
    chk("sticky_clean", 33'(err_sticky), 33'd0);
    for (int i = 1; i < 30; i++) send(tv[i]);
    drain();
    chk("sticky_set", 33'(err_sticky), 33'd1);
    chk("word_cnt_table", 33'(word_cnt), 33'(pops));
    do_reset();
    out_ready = 0;
    send(tv[0]);
    send(tv[5]);
    chk("full_in_ready", 33'(in_ready), 33'd0);
    fork send(tv[17]); join_none
    idle(3);
    chk("held_in_ready", 33'(in_ready), 33'd0);
    chk("held_addr", {1'b0, out_addr}, {1'b0, BASE});
    chk("held_qsize", 33'(q.size()), 33'd2);
    out_ready = 1;
    idle(1);
    drain();
    chk("word_cnt_3", 33'(word_cnt), 33'd3);
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] imm = {20'($urandom), 12'h0};
      logic [4:0]  rd  = 5'($urandom);
      send(mk(6, 0, 0, rd, 0, 0, imm, {1'b0, imm[31:12], rd, 7'b0110111}));
    end
    rand_rdy = 0;
    idle(2);
    out_ready = 1;
    drain();
    chk("word_cnt_rand", 33'(word_cnt), 33'd23);
    out_ready = 0;
    send(tv[0]);
    send(tv[4]);
    chk("pre_rst_valid", 33'(out_valid), 33'd1);
    chk("pre_rst_sticky", 33'(err_sticky), 33'd1);
    rst = 1;
    q.delete();
    @(negedge clk);
    chk("during_rst_valid", 33'(out_valid), 33'd0);
    @(posedge clk);
    #1 rst = 0;
    exp_addr = BASE;
    pops = 0;
    chk("post_rst_valid", 33'(out_valid), 33'd0);
    chk("post_rst_word_cnt", 33'(word_cnt), 33'd0);
    chk("post_rst_sticky", 33'(err_sticky), 33'd0);
    @(negedge clk);
    chk("post_rst_valid_1", 33'(out_valid), 33'd0);
    idle(1);
    out_ready = 1;
    send(tv[23]);
    drain();
    chk("post_rst_word_cnt_1", 33'(word_cnt), 33'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
